// File: rtl/fab_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : fab_bitstream_loader
// Description : Streams a byte-wide memory image into the eFPGA serial config
//               port, interleaving each data bit with one control-word bit,
//               then pulses the fabric user reset.
// Revision    : 1.0 - initial release
// ============================================================================

module fab_bitstream_loader #(
    parameter int          NUM_BYTES    = 16384,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] CTRL_WORD    = 32'h0000FAB1,
    parameter int          POST_WAIT    = 100,
    parameter int          USER_RST_CYC = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-2:0] len_words,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              s_clk,
    output logic              s_data,
    output logic              user_rst,
    output logic              busy,
    output logic              done
);

    localparam int c_WCNT_W   = ADDR_W - 1;
    localparam int c_CNT_MAX0 = (POST_WAIT > USER_RST_CYC) ? POST_WAIT : USER_RST_CYC;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > 5) ? c_CNT_MAX0 : 5;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    localparam logic [c_WCNT_W-1:0] c_MAX_WORDS  = c_WCNT_W'(NUM_BYTES / 4);
    localparam logic [c_WCNT_W-1:0] c_WORD_ONE   = c_WCNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_FETCH_LAST = c_CNT_W'(4);
    localparam logic [c_CNT_W-1:0]  c_PW_LAST    = c_CNT_W'(POST_WAIT - 1);
    localparam logic [c_CNT_W-1:0]  c_UR_LAST    = c_CNT_W'(USER_RST_CYC - 1);
    localparam logic [31:0]         c_CTRL       = CTRL_WORD;

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_FETCH     = 4'd1;
    localparam logic [3:0] c_ST_BIT_SETUP = 4'd2;
    localparam logic [3:0] c_ST_BIT_RISE  = 4'd3;
    localparam logic [3:0] c_ST_BIT_CTRL  = 4'd4;
    localparam logic [3:0] c_ST_BIT_LOW   = 4'd5;
    localparam logic [3:0] c_ST_POSTWAIT  = 4'd6;
    localparam logic [3:0] c_ST_USERRST   = 4'd7;
    localparam logic [3:0] c_ST_DONE      = 4'd8;

    logic [3:0]          r_state_q,    w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,      w_cnt_d;
    logic [4:0]          r_bit_q,      w_bit_d;
    logic [c_WCNT_W-1:0] r_word_idx_q, w_word_idx_d;
    logic [c_WCNT_W-1:0] r_nwords_q,   w_nwords_d;
    logic [31:0]         r_shift_q,    w_shift_d;

    logic                r_mem_rd_q,   w_mem_rd_d;
    logic [ADDR_W-1:0]   r_mem_addr_q, w_mem_addr_d;
    logic                r_s_clk_q,    w_s_clk_d;
    logic                r_s_data_q,   w_s_data_d;
    logic                r_user_rst_q, w_user_rst_d;
    logic                r_busy_q,     w_busy_d;
    logic                r_done_q,     w_done_d;

    // Sequencing: counters and state advance.
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_bit_d      = r_bit_q;
        w_word_idx_d = r_word_idx_q;
        w_nwords_d   = r_nwords_q;
        w_shift_d    = r_shift_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (start) begin
                    w_nwords_d   = (len_words > c_MAX_WORDS) ? c_MAX_WORDS : len_words;
                    w_word_idx_d = '0;
                    w_bit_d      = '0;
                    w_cnt_d      = '0;
                    w_state_d    = (w_nwords_d == '0) ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                // Read data trails the strobe by one cycle, so capture on cycles 1..4.
                if (r_cnt_q != '0) begin
                    w_shift_d = {r_shift_q[23:0], mem_data};
                end
                if (r_cnt_q == c_FETCH_LAST) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = c_ST_BIT_SETUP;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_ST_BIT_SETUP: w_state_d = c_ST_BIT_RISE;
            c_ST_BIT_RISE:  w_state_d = c_ST_BIT_CTRL;
            c_ST_BIT_CTRL: begin
                w_cnt_d   = '0;
                w_state_d = c_ST_BIT_LOW;
            end
            c_ST_BIT_LOW: begin
                if (r_cnt_q == '0) begin
                    w_cnt_d = c_CNT_ONE;
                end else begin
                    w_cnt_d = '0;
                    if (r_bit_q != 5'd31) begin
                        w_bit_d   = r_bit_q + 5'd1;
                        w_state_d = c_ST_BIT_SETUP;
                    end else if ((r_word_idx_q + c_WORD_ONE) != r_nwords_q) begin
                        w_word_idx_d = r_word_idx_q + c_WORD_ONE;
                        w_state_d    = c_ST_FETCH;
                    end else begin
                        w_state_d = c_ST_POSTWAIT;
                    end
                end
            end
            c_ST_POSTWAIT: begin
                if (r_cnt_q == c_PW_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = c_ST_USERRST;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_ST_USERRST: begin
                if (r_cnt_q == c_UR_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = c_ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_ST_DONE: w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase

        // Cancel wins over any advance computed above.
        if (abort && (r_state_q != c_ST_IDLE)) begin
            w_state_d    = c_ST_IDLE;
            w_cnt_d      = '0;
            w_bit_d      = '0;
            w_word_idx_d = '0;
        end
    end

    // Outputs are decoded from the next state so every pin leaves a flop.
    always_comb begin
        w_s_clk_d    = 1'b0;
        w_s_data_d   = 1'b0;
        w_mem_rd_d   = 1'b0;
        w_mem_addr_d = r_mem_addr_q;
        w_user_rst_d = 1'b0;
        w_busy_d     = 1'b1;
        w_done_d     = 1'b0;

        case (w_state_d)
            c_ST_IDLE: w_busy_d = 1'b0;
            c_ST_FETCH: begin
                w_s_data_d = r_s_data_q;
                if (w_cnt_d != c_FETCH_LAST) begin
                    w_mem_rd_d   = 1'b1;
                    w_mem_addr_d = {w_word_idx_d[ADDR_W-3:0], w_cnt_d[1:0]};
                end
            end
            c_ST_BIT_SETUP: w_s_data_d = w_shift_d[5'd31 - w_bit_d];
            c_ST_BIT_RISE: begin
                w_s_clk_d  = 1'b1;
                w_s_data_d = w_shift_d[5'd31 - w_bit_d];
            end
            c_ST_BIT_CTRL: begin
                w_s_clk_d  = 1'b1;
                w_s_data_d = c_CTRL[5'd31 - w_bit_d];
            end
            c_ST_BIT_LOW:  w_s_data_d = c_CTRL[5'd31 - w_bit_d];
            c_ST_POSTWAIT: w_s_data_d = 1'b0;
            c_ST_USERRST:  w_user_rst_d = 1'b1;
            c_ST_DONE: begin
                w_busy_d = 1'b0;
                w_done_d = 1'b1;
            end
            default: w_busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= c_ST_IDLE;
            r_cnt_q      <= '0;
            r_bit_q      <= '0;
            r_word_idx_q <= '0;
            r_nwords_q   <= '0;
            r_shift_q    <= '0;
            r_mem_rd_q   <= 1'b0;
            r_mem_addr_q <= '0;
            r_s_clk_q    <= 1'b0;
            r_s_data_q   <= 1'b0;
            r_user_rst_q <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_bit_q      <= w_bit_d;
            r_word_idx_q <= w_word_idx_d;
            r_nwords_q   <= w_nwords_d;
            r_shift_q    <= w_shift_d;
            r_mem_rd_q   <= w_mem_rd_d;
            r_mem_addr_q <= w_mem_addr_d;
            r_s_clk_q    <= w_s_clk_d;
            r_s_data_q   <= w_s_data_d;
            r_user_rst_q <= w_user_rst_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
        end
    end

    assign mem_rd   = r_mem_rd_q;
    assign mem_addr = r_mem_addr_q;
    assign s_clk    = r_s_clk_q;
    assign s_data   = r_s_data_q;
    assign user_rst = r_user_rst_q;
    assign busy     = r_busy_q;
    assign done     = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fab_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fab_bitstream_loader
// Description : Scoreboard bench for fab_bitstream_loader with a small buffer.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fab_bitstream_loader;

    localparam int          NUM_BYTES    = 64;
    localparam int          ADDR_W       = 6;
    localparam int          POST_WAIT    = 100;
    localparam int          USER_RST_CYC = 5;
    localparam int          MAX_WORDS    = NUM_BYTES / 4;
    localparam int          WORD_CYC     = 5 + 32 * 5;
    localparam logic [31:0] CTRL         = 32'h0000FAB1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-2:0] len_words;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data = 8'h00;
    logic              s_clk;
    logic              s_data;
    logic              user_rst;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    fab_bitstream_loader #(
        .NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W), .CTRL_WORD(CTRL),
        .POST_WAIT(POST_WAIT), .USER_RST_CYC(USER_RST_CYC)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .len_words(len_words), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .s_clk(s_clk), .s_data(s_data),
        .user_rst(user_rst), .busy(busy), .done(done)
    );

    logic [7:0] mem [NUM_BYTES];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int          exp_addr[$];
    logic [31:0] exp_word[$];
    logic [31:0] exp_ctrl[$];
    int          exp_done[$];
    int          exp_urst[$];
    int          done_seen = 0;
    int          mon_clear = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reconstructs words from s_clk edges and pops the scoreboard.
    logic        prev_sclk = 1'b0;
    logic        prev_urst = 1'b0;
    logic [31:0] dacc = '0;
    logic [31:0] cacc = '0;
    int          rises = 0;
    int          falls = 0;
    int          urst_len = 0;

    always @(negedge clk) begin
        if (mon_clear > 0) begin
            mon_clear--;
            rises = 0; falls = 0; dacc = '0; cacc = '0; urst_len = 0;
        end else if (!reset) begin
            if (!busy && s_clk) check("sclk_while_idle", s_clk, 1'b0);
            if (mem_rd) begin
                if (exp_addr.size() == 0) check("mem_rd_unexpected", 1, 0);
                else check("mem_addr", mem_addr, exp_addr.pop_front());
                check("fetch_sclk_low", s_clk, 1'b0);
            end
            if (s_clk && !prev_sclk) begin
                dacc = {dacc[30:0], s_data};
                rises++;
                if (rises == 32) begin
                    if (exp_word.size() == 0) check("word_unexpected", 1, 0);
                    else check("data_word", dacc, exp_word.pop_front());
                    rises = 0;
                end
            end
            if (!s_clk && prev_sclk) begin
                cacc = {cacc[30:0], s_data};
                falls++;
                if (falls == 32) begin
                    if (exp_ctrl.size() == 0) check("ctrl_unexpected", 1, 0);
                    else check("ctrl_word", cacc, exp_ctrl.pop_front());
                    falls = 0;
                end
            end
            if (user_rst && !prev_urst) begin
                if (exp_urst.size() == 0) check("user_rst_unexpected", 1, 0);
                else check("user_rst_start", cyc, exp_urst.pop_front());
            end
            if (user_rst) urst_len++;
            if (!user_rst && prev_urst) begin
                check("user_rst_width", urst_len, USER_RST_CYC);
                urst_len = 0;
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, exp_done.pop_front());
                check("done_busy_low", busy, 1'b0);
            end
        end
        prev_sclk = s_clk;
        prev_urst = user_rst;
    end

    task automatic flush();
        exp_addr.delete(); exp_word.delete(); exp_ctrl.delete();
        exp_done.delete(); exp_urst.delete();
        mon_clear = 2;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_BYTES; i++) mem[i] = 8'($urandom);
    endtask

    // Reference model: expectations straight from the load rules.
    task automatic load(input int len, output int p);
        int n;
        n = (len > MAX_WORDS) ? MAX_WORDS : len;
        @(posedge clk); #1;
        p = cyc;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) exp_addr.push_back(4 * w + k);
            exp_word.push_back({mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]});
            exp_ctrl.push_back(CTRL);
        end
        if (n > 0) exp_urst.push_back(p + 1 + WORD_CYC * n + POST_WAIT);
        exp_done.push_back(p + 1 + WORD_CYC * n + ((n > 0) ? POST_WAIT + USER_RST_CYC : 0));
        start = 1'b1;
        len_words = len[ADDR_W-2:0];
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, (n > 0) ? 1'b1 : 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_seen;
        k = 0;
        while (done_seen == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("done_within_budget", (done_seen > d0) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        check("scoreboard_drained",
              exp_addr.size() + exp_word.size() + exp_ctrl.size() + exp_urst.size() + exp_done.size(), 0);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_clk"}, s_clk, 1'b0);
        check({tag, "_s_data"}, s_data, 1'b0);
        check({tag, "_mem_rd"}, mem_rd, 1'b0);
        check({tag, "_user_rst"}, user_rst, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        reset = 1'b1; start = 1'b0; abort = 1'b0; len_words = '0;
        for (int i = 0; i < NUM_BYTES; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_mem_addr", mem_addr, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single known word.
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
        load(1, p);
        wait_done(WORD_CYC + 200);

        // Three distinct words.
        fill_random();
        load(3, p);
        wait_done(3 * WORD_CYC + 200);

        // Zero length: done next cycle, nothing else.
        load(0, p);
        wait_done(20);

        // Random short loads and one clamped to the buffer size.
        for (int i = 0; i < 3; i++) begin
            fill_random();
            load($urandom_range(1, 4), p);
            wait_done(4 * WORD_CYC + 200);
        end
        fill_random();
        load($urandom_range(MAX_WORDS + 1, 31), p);
        wait_done(MAX_WORDS * WORD_CYC + 200);

        // Abort at word 1, bit 10 (BIT_CTRL), with an ignored start on the way.
        fill_random();
        load(4, p);
        goto(p + 30);
        start = 1'b1; len_words = 1;
        @(posedge clk); #1;
        start = 1'b0;
        goto(p + 1 + WORD_CYC + 5 + 10 * 5 + 2);
        abort = 1'b1;
        flush();
        @(negedge clk);
        check("abort_pre_sclk_high", s_clk, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        repeat (300) @(posedge clk);
        #1;
        load(1, p);
        wait_done(WORD_CYC + 200);

        // Reset while s_clk is high in BIT_CTRL of word 0, bit 3.
        fill_random();
        load(2, p);
        goto(p + 1 + 5 + 3 * 5 + 2);
        reset = 1'b1;
        flush();
        @(negedge clk);
        check("reset_pre_sclk_high", s_clk, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("midreset");
        check("midreset_mem_addr", mem_addr, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        fill_random();
        load(1, p);
        wait_done(WORD_CYC + 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
